// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response handshake bundle between a requester and seq_alu
interface seq_alu_if #(
   parameter int BUS_WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [BUS_WIDTH-1:0] src_a;
   logic [BUS_WIDTH-1:0] src_b;
   logic [3:0]           alu_op;
   logic                 out_valid;
   logic                 out_ready;
   logic [BUS_WIDTH-1:0] alu_result;
   logic                 zero;

   modport master (
      output in_valid, src_a, src_b, alu_op, out_ready,
      input  in_ready, out_valid, alu_result, zero
   );

   modport slave (
      input  in_valid, src_a, src_b, alu_op, out_ready,
      output in_ready, out_valid, alu_result, zero
   );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle logic/arith ops and bit-serial MUL/DIVU/REMU
module seq_alu #(
   parameter int BUS_WIDTH = 32
) (
   input logic      clk,
   input logic      rst_n,
   seq_alu_if.slave bus
);
   localparam int CNT_W = $clog2(BUS_WIDTH) + 1;
   localparam int SH_W  = $clog2(BUS_WIDTH);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_OR   = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_SLT  = 4'h5;
   localparam logic [3:0] OP_SLTU = 4'h6;
   localparam logic [3:0] OP_SLL  = 4'h7;
   localparam logic [3:0] OP_SRL  = 4'h8;
   localparam logic [3:0] OP_SRA  = 4'h9;
   localparam logic [3:0] OP_MUL  = 4'hA;
   localparam logic [3:0] OP_DIVU = 4'hB;
   localparam logic [3:0] OP_REMU = 4'hC;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [3:0]           op_q, op_d;
   logic [BUS_WIDTH-1:0] a_q, a_d;
   logic [BUS_WIDTH-1:0] b_q, b_d;
   logic [BUS_WIDTH-1:0] acc_q, acc_d;
   logic [BUS_WIDTH-1:0] result_q, result_d;
   logic                 zero_q, zero_d;

   logic [SH_W-1:0]      sh;
   logic [BUS_WIDTH-1:0] fast_res;
   logic [BUS_WIDTH-1:0] mul_acc;
   logic [BUS_WIDTH:0]   rem_sh;
   logic                 rem_ge;
   logic [BUS_WIDTH-1:0] rem_next;
   logic [BUS_WIDTH-1:0] quo_next;
   logic [BUS_WIDTH-1:0] done_res;
   logic                 iter_op;

   // Single-cycle result computed straight from the request operands
   always_comb begin
      sh       = bus.src_b[SH_W-1:0];
      fast_res = '0;
      case (bus.alu_op)
         OP_ADD:  fast_res = bus.src_a + bus.src_b;
         OP_SUB:  fast_res = bus.src_a - bus.src_b;
         OP_OR:   fast_res = bus.src_a | bus.src_b;
         OP_AND:  fast_res = bus.src_a & bus.src_b;
         OP_XOR:  fast_res = bus.src_a ^ bus.src_b;
         OP_SLT:  fast_res = BUS_WIDTH'($signed(bus.src_a) < $signed(bus.src_b));
         OP_SLTU: fast_res = BUS_WIDTH'(bus.src_a < bus.src_b);
         OP_SLL:  fast_res = bus.src_a << sh;
         OP_SRL:  fast_res = bus.src_a >> sh;
         OP_SRA:  fast_res = $signed(bus.src_a) >>> sh;
         default: fast_res = '0;
      endcase
   end

   // One iteration step: shift-add for MUL, restoring subtract for DIVU/REMU (quotient shifts into a_q)
   always_comb begin
      mul_acc  = acc_q + (b_q[0] ? a_q : '0);
      rem_sh   = {acc_q, a_q[BUS_WIDTH-1]};
      rem_ge   = rem_sh >= {1'b0, b_q};
      rem_next = rem_ge ? BUS_WIDTH'(rem_sh - {1'b0, b_q}) : BUS_WIDTH'(rem_sh);
      quo_next = {a_q[BUS_WIDTH-2:0], rem_ge};
      done_res = (op_q == OP_MUL) ? mul_acc : (op_q == OP_DIVU) ? quo_next : rem_next;
   end

   // Next state: accept in IDLE, iterate in BUSY, hold the result in DONE until consumed
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      zero_d   = zero_q;
      iter_op  = bus.alu_op inside {OP_MUL, OP_DIVU, OP_REMU};
      case (state_q)
         IDLE: if (bus.in_valid) begin
            op_d  = bus.alu_op;
            a_d   = bus.src_a;
            b_d   = bus.src_b;
            acc_d = '0;
            if (iter_op) begin
               state_d = BUSY;
               cnt_d   = CNT_W'(BUS_WIDTH);
            end else begin
               state_d  = DONE;
               result_d = fast_res;
               zero_d   = (fast_res == '0);
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            a_d   = (op_q == OP_MUL) ? a_q << 1 : quo_next;
            b_d   = (op_q == OP_MUL) ? b_q >> 1 : b_q;
            acc_d = (op_q == OP_MUL) ? mul_acc : rem_next;
            if (cnt_q == CNT_W'(1)) begin
               state_d  = DONE;
               result_d = done_res;
               zero_d   = (done_res == '0);
            end
         end
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.out_valid  = (state_q == DONE);
   assign bus.alu_result = result_q;
   assign bus.zero       = zero_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors for seq_alu checked against literals and a latency/arithmetic model
module tb_seq_alu;
   localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, OR_ = 4'h2, AND_ = 4'h3, XOR_ = 4'h4;
   localparam logic [3:0] SLT = 4'h5, SLTU = 4'h6, SLL = 4'h7, SRL = 4'h8, SRA = 4'h9;
   localparam logic [3:0] MUL = 4'hA, DIVU = 4'hB, REMU = 4'hC;

   logic clk;
   logic rst_n;
   bit   chk_on;
   int   tests;
   int   fails;

   seq_alu_if #(.BUS_WIDTH(32)) bus ();

   seq_alu #(.BUS_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference arithmetic for every op code, written from the op definitions
   function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ADD:     return a + b;
         SUB:     return a - b;
         OR_:     return a | b;
         AND_:    return a & b;
         XOR_:    return a ^ b;
         SLT:     return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         SLTU:    return (a < b) ? 32'd1 : 32'd0;
         SLL:     return a << b[4:0];
         SRL:     return a >> b[4:0];
         SRA:     return 32'($signed(a) >>> b[4:0]);
         MUL:     return 32'(64'(a) * 64'(b));
         DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REMU:    return (b == 0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   // Model: result appears 1 cycle after acceptance, or 33 for the iterative ops
   logic        m_valid;
   int          m_wait;
   logic [31:0] m_res;
   logic        m_zero;
   logic [31:0] m_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_wait  <= 0;
         m_res   <= '0;
         m_zero  <= 1'b0;
      end else if (m_valid) begin
         if (bus.out_ready) m_valid <= 1'b0;
      end else if (m_wait > 1) begin
         m_wait <= m_wait - 1;
      end else if (m_wait == 1) begin
         m_wait  <= 0;
         m_valid <= 1'b1;
         m_res   <= m_pend;
         m_zero  <= (m_pend == 0);
      end else if (bus.in_valid) begin
         if (bus.alu_op inside {MUL, DIVU, REMU}) begin
            m_wait <= 32;
            m_pend <= model_res(bus.alu_op, bus.src_a, bus.src_b);
         end else begin
            m_valid <= 1'b1;
            m_res   <= model_res(bus.alu_op, bus.src_a, bus.src_b);
            m_zero  <= (model_res(bus.alu_op, bus.src_a, bus.src_b) == 0);
         end
      end
   end

   // Compare every DUT output against the model once per cycle
   always @(negedge clk) begin
      if (chk_on) begin
         chk("cmp_in_ready", 32'(bus.in_ready), 32'(!m_valid && m_wait == 0));
         chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_valid));
         chk("cmp_result", bus.alu_result, m_res);
         chk("cmp_zero", 32'(bus.zero), 32'(m_zero));
      end
   end

   // One request with literal expectation, garbage requests while busy, hold then consume
   task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int hold);
      int lat;
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.alu_op    = op;
      bus.src_a     = a;
      bus.src_b     = b;
      bus.out_ready = 1'b0;
      chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.alu_op = ADD;
      bus.src_a  = 32'h1111_1111;
      bus.src_b  = 32'h2222_2222;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         chk({name, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      for (int i = 0; i < hold; i++) begin
         chk({name, "_out_valid"}, 32'(bus.out_valid), 32'd1);
         chk({name, "_result"}, bus.alu_result, exp);
         chk({name, "_zero"}, 32'(bus.zero), 32'(exp == 0));
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk({name, "_retire_valid"}, 32'(bus.out_valid), 32'd0);
      chk({name, "_retire_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      clk           = 1'b0;
      rst_n         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.alu_op    = '0;
      bus.src_a     = '0;
      bus.src_b     = '0;
      bus.out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.alu_result, 32'd0);
      chk("rst_zero", 32'(bus.zero), 32'd0);
      chk_on = 1'b1;
      #20 rst_n = 1'b1;

      do_op("add",   ADD,  32'd3,          32'd4,          32'd7,          1, 1);
      do_op("sub",   SUB,  32'd5,          32'd7,          32'hFFFF_FFFE,  1, 1);
      do_op("slt",   SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,          1, 1);
      do_op("sltu",  SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,          1, 1);
      do_op("or",    OR_,  32'hF0F0_0000,  32'h0000_0F0F,  32'hF0F0_0F0F,  1, 1);
      do_op("and",   AND_, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1, 1);
      do_op("xor",   XOR_, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555,  1, 1);
      do_op("sra",   SRA,  32'h8000_0000,  32'h0000_0024,  32'hF800_0000,  1, 1);
      do_op("srl",   SRL,  32'h8000_0000,  32'h0000_0024,  32'h0800_0000,  1, 1);
      do_op("sll",   SLL,  32'h8000_0000,  32'h0000_0024,  32'd0,          1, 1);
      do_op("op_d",  4'hD, 32'd5,          32'd7,          32'd0,          1, 1);
      do_op("op_f",  4'hF, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          1, 1);
      do_op("mul",   MUL,  32'h0001_0003,  32'h0000_0010,  32'h0010_0030, 33, 1);
      do_op("mulw",  MUL,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,         33, 1);
      do_op("divu",  DIVU, 32'd100,        32'd7,          32'd14,        33, 1);
      do_op("remu",  REMU, 32'd100,        32'd7,          32'd2,         33, 1);
      do_op("div0",  DIVU, 32'h0000_DEAD,  32'd0,          32'hFFFF_FFFF, 33, 1);
      do_op("rem0",  REMU, 32'h0000_1234,  32'd0,          32'h0000_1234, 33, 1);
      do_op("divh",  DIVU, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0FFF_FFFF, 33, 1);
      do_op("remh",  REMU, 32'hFFFF_FFFF,  32'h0000_0010,  32'h0000_000F, 33, 1);
      do_op("sub0",  SUB,  32'd5,          32'd5,          32'd0,          1, 10);

      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.alu_op   = DIVU;
      bus.src_a    = 32'd1000;
      bus.src_b    = 32'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_result", bus.alu_result, 32'd0);
      chk("abort_zero", 32'(bus.zero), 32'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
      end
      do_op("post_add", ADD, 32'd1, 32'd1, 32'd2, 1, 1);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
